// File: rtl/hilo_muldiv_unit.sv
// HI/LO register owner: MULT/MULTU capture, MTHI/MTLO, 32-step restoring DIV/DIVU.
// Optional HILO_BYPASS_EN: hi_o/lo_o forward the value being written this cycle.
module hilo_muldiv_unit #(
    parameter int DIV_CYCLES = 32
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        valid_i,
    input  logic [4:0]  aluop_i,
    input  logic [31:0] src0_i,
    input  logic [31:0] src1_i,
    input  logic [63:0] aluout_i,
    input  logic        mthi_i,
    input  logic        mtlo_i,
    input  logic        flush_i,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        busy_o,
    output logic        done_o
);

    localparam logic [4:0] ALUOP_MULT  = 5'h10;
    localparam logic [4:0] ALUOP_MULTU = 5'h11;
    localparam logic [4:0] ALUOP_DIV   = 5'h12;
    localparam logic [4:0] ALUOP_DIVU  = 5'h13;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_DIV_RUN = 2'd1;
    localparam logic [1:0] S_DIV_FIX = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] dvd_q, dvd_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] dvs_q, dvs_d;
    logic        qs_q, qs_d;
    logic        rs_q, rs_d;
    logic        dz_q, dz_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic        is_mul, is_div, is_sdiv, accept;
    logic [32:0] shifted, diff;
    logic [31:0] abs0, abs1;

    assign is_mul  = (aluop_i == ALUOP_MULT) | (aluop_i == ALUOP_MULTU);
    assign is_div  = (aluop_i == ALUOP_DIV) | (aluop_i == ALUOP_DIVU);
    assign is_sdiv = (aluop_i == ALUOP_DIV);
    assign accept  = valid_i & (state_q == S_IDLE) & ~flush_i;

    assign abs0 = src0_i[31] ? -src0_i : src0_i;
    assign abs1 = src1_i[31] ? -src1_i : src1_i;

    // 33-bit partial remainder so divisors >= 2^31 compare correctly
    assign shifted = {rem_q, dvd_q[31]};
    assign diff    = shifted - {1'b0, dvs_q};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dvd_d   = dvd_q;
        rem_d   = rem_q;
        dvs_d   = dvs_q;
        qs_d    = qs_q;
        rs_d    = rs_q;
        dz_d    = dz_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        unique case (state_q)
            S_DIV_RUN: begin
                if (flush_i) begin
                    state_d = S_IDLE;
                end else begin
                    if (!diff[32]) begin
                        rem_d = diff[31:0];
                        dvd_d = {dvd_q[30:0], 1'b1};
                    end else begin
                        rem_d = shifted[31:0];
                        dvd_d = {dvd_q[30:0], 1'b0};
                    end
                    cnt_d = cnt_q - 5'd1;
                    if (cnt_q == 5'd0) state_d = S_DIV_FIX;
                end
            end
            S_DIV_FIX: begin
                state_d = S_IDLE;
                if (!flush_i) begin
                    // divide by zero leaves the quotient un-negated
                    lo_d = dz_q ? 32'hFFFF_FFFF : (qs_q ? -dvd_q : dvd_q);
                    hi_d = rs_q ? -rem_q : rem_q;
                end
            end
            default: begin
                if (accept) begin
                    if (is_mul) begin
                        hi_d = aluout_i[63:32];
                        lo_d = aluout_i[31:0];
                    end else if (is_div) begin
                        state_d = S_DIV_RUN;
                        cnt_d   = 5'(DIV_CYCLES - 1);
                        rem_d   = 32'd0;
                        dz_d    = (src1_i == 32'd0);
                        dvd_d   = is_sdiv ? abs0 : src0_i;
                        dvs_d   = is_sdiv ? abs1 : src1_i;
                        qs_d    = is_sdiv & (src0_i[31] ^ src1_i[31]);
                        rs_d    = is_sdiv & src0_i[31];
                    end else begin
                        if (mthi_i) hi_d = src0_i;
                        if (mtlo_i) lo_d = src0_i;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
            cnt_q   <= 5'd0;
            dvd_q   <= 32'd0;
            rem_q   <= 32'd0;
            dvs_q   <= 32'd0;
            qs_q    <= 1'b0;
            rs_q    <= 1'b0;
            dz_q    <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dvd_q   <= dvd_d;
            rem_q   <= rem_d;
            dvs_q   <= dvs_d;
            qs_q    <= qs_d;
            rs_q    <= rs_d;
            dz_q    <= dz_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy_o = (state_q != S_IDLE)
                  | (valid_i & (state_q == S_IDLE) & is_div);
    assign done_o = (state_q == S_DIV_FIX) & ~flush_i;

`ifdef HILO_BYPASS_EN
    assign hi_o = hi_d;
    assign lo_o = lo_d;
`else
    assign hi_o = hi_q;
    assign lo_o = lo_q;
`endif

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed-vector bench for hilo_muldiv_unit.
// Single-cycle ops come from a table; divides and corner cases are hand sequences.
module tb_hilo_muldiv_unit;

    localparam logic [4:0] OP_MULT  = 5'h10;
    localparam logic [4:0] OP_MULTU = 5'h11;
    localparam logic [4:0] OP_DIV   = 5'h12;
    localparam logic [4:0] OP_DIVU  = 5'h13;
    localparam logic [4:0] OP_OTHER = 5'h01;

    logic        clk, rst_n;
    logic        valid, mthi, mtlo, flush;
    logic [4:0]  aluop;
    logic [31:0] src0, src1;
    logic [63:0] aluout;
    logic [31:0] hi, lo;
    logic        busy, done;

    int n_chk = 0;
    int n_fail = 0;

    hilo_muldiv_unit dut (
        .clk_i(clk), .rst_n_i(rst_n), .valid_i(valid), .aluop_i(aluop),
        .src0_i(src0), .src1_i(src1), .aluout_i(aluout),
        .mthi_i(mthi), .mtlo_i(mtlo), .flush_i(flush),
        .hi_o(hi), .lo_o(lo), .busy_o(busy), .done_o(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        valid;
        logic [4:0]  op;
        logic [31:0] s0;
        logic [63:0] aout;
        logic        mthi;
        logic        mtlo;
        logic        flush;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        valid = 0; aluop = OP_OTHER; src0 = 0; src1 = 0;
        aluout = 0; mthi = 0; mtlo = 0; flush = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_div(input string nm, input logic [4:0] op,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_lo, input logic [31:0] exp_hi);
        int bcnt, dcnt;
        bcnt = 0;
        dcnt = 0;
        valid = 1; aluop = op; src0 = a; src1 = b;
        #1;
        for (int n = 0; n < 45; n++) begin
            if (busy) bcnt++;
            if (done) dcnt++;
            step();
            valid = 0; aluop = OP_OTHER;
            if (!busy && !done) break;
        end
        check({nm, " busy_cycles"}, bcnt, 34);
        check({nm, " done_pulses"}, dcnt, 1);
        check({nm, " lo"}, lo, exp_lo);
        check({nm, " hi"}, hi, exp_hi);
        idle_inputs();
    endtask

    initial begin
        int dcnt;
        logic [31:0] hi_keep, lo_keep;

        vecs[0] = '{"mult_neg", 1, OP_MULT, 0, 64'hFFFF_FFFF_FFFF_FFFE,
                    0, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
        vecs[1] = '{"multu", 1, OP_MULTU, 0, 64'h0000_0001_0000_0002,
                    0, 0, 0, 32'h1, 32'h2};
        vecs[2] = '{"mthi", 1, OP_OTHER, 32'hA5A5, 0,
                    1, 0, 0, 32'hA5A5, 32'h2};
        vecs[3] = '{"mtlo", 1, OP_OTHER, 32'h1111, 0,
                    0, 1, 0, 32'hA5A5, 32'h1111};
        vecs[4] = '{"mthi_mtlo", 1, OP_OTHER, 32'h7777, 0,
                    1, 1, 0, 32'h7777, 32'h7777};
        vecs[5] = '{"mult_over_mthi", 1, OP_MULT, 32'h9999,
                    64'h0000_0003_0000_0004, 1, 1, 0, 32'h3, 32'h4};
        vecs[6] = '{"invalid_mult", 0, OP_MULT, 0,
                    64'hDEAD_BEEF_CAFE_F00D, 0, 0, 0, 32'h3, 32'h4};
        vecs[7] = '{"flush_mthi", 1, OP_OTHER, 32'hBBBB, 0,
                    1, 1, 1, 32'h3, 32'h4};
        vecs[8] = '{"other_op", 1, OP_OTHER, 32'hCCCC,
                    64'h1234_5678_9ABC_DEF0, 0, 0, 0, 32'h3, 32'h4};
        vecs[9] = '{"multu_hi_bit", 1, OP_MULTU, 0,
                    64'h8000_0000_0000_0000, 0, 0, 0, 32'h8000_0000, 32'h0};

        idle_inputs();
        rst_n = 0;
        #12;
        check("reset hi", hi, 0);
        check("reset lo", lo, 0);
        check("reset busy", {31'd0, busy}, 0);
        check("reset done", {31'd0, done}, 0);
        rst_n = 1;
        step();

        foreach (vecs[i]) begin
            valid = vecs[i].valid; aluop = vecs[i].op; src0 = vecs[i].s0;
            aluout = vecs[i].aout; mthi = vecs[i].mthi;
            mtlo = vecs[i].mtlo; flush = vecs[i].flush;
            #1;
            check({vecs[i].name, " busy"}, {31'd0, busy}, 0);
            step();
            idle_inputs();
            #1;
            check({vecs[i].name, " hi"}, hi, vecs[i].exp_hi);
            check({vecs[i].name, " lo"}, lo, vecs[i].exp_lo);
        end

        run_div("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2,
                32'hFFFF_FFFD, 32'hFFFF_FFFF);
        run_div("div_7_m2", OP_DIV, 32'd7, 32'hFFFF_FFFE,
                32'hFFFF_FFFD, 32'h1);
        run_div("divu_big_16", OP_DIVU, 32'hFFFF_FFFF, 32'd16,
                32'h0FFF_FFFF, 32'hF);
        run_div("divu_big_dvs", OP_DIVU, 32'hFFFF_FFFF, 32'h8000_0001,
                32'h1, 32'h7FFF_FFFE);
        run_div("div_5_0", OP_DIV, 32'd5, 32'd0,
                32'hFFFF_FFFF, 32'd5);
        run_div("div_m5_0", OP_DIV, 32'hFFFF_FFFB, 32'd0,
                32'hFFFF_FFFF, 32'hFFFF_FFFB);
        run_div("divu_9_0", OP_DIVU, 32'd9, 32'd0,
                32'hFFFF_FFFF, 32'd9);
        run_div("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF,
                32'h8000_0000, 32'h0);

        // flush at iteration 20 discards the divide
        hi_keep = hi;
        lo_keep = lo;
        valid = 1; aluop = OP_DIV; src0 = 32'd100; src1 = 32'd7;
        step();
        idle_inputs();
        dcnt = 0;
        for (int n = 0; n < 20; n++) begin
            if (done) dcnt++;
            step();
        end
        flush = 1;
        #1;
        check("flush busy_during", {31'd0, busy}, 1);
        step();
        flush = 0;
        #1;
        check("flush busy_after", {31'd0, busy}, 0);
        check("flush done_count", dcnt, 0);
        check("flush hi", hi, hi_keep);
        check("flush lo", lo, lo_keep);
        valid = 1; mtlo = 1; src0 = 32'h1234;
        step();
        idle_inputs();
        #1;
        check("post_flush mtlo lo", lo, 32'h1234);
        check("post_flush mtlo hi", hi, hi_keep);
        dcnt = 0;
        for (int n = 0; n < 16; n++) begin
            if (done) dcnt++;
            step();
        end
        check("post_flush no done", dcnt, 0);

        // MTHI then MFHI: forwarding visibility depends on build
        hi_keep = hi;
        valid = 1; mthi = 1; src0 = 32'hA5A5;
        #1;
`ifdef HILO_BYPASS_EN
        check("mthi write_cycle hi", hi, 32'hA5A5);
`else
        check("mthi write_cycle hi", hi, hi_keep);
`endif
        step();
        idle_inputs();
        #1;
        check("mthi next_cycle hi", hi, 32'hA5A5);

        // reset at cycle 10 of DIV_RUN
        valid = 1; aluop = OP_DIVU; src0 = 32'd1000; src1 = 32'd3;
        step();
        idle_inputs();
        for (int n = 0; n < 10; n++) step();
        rst_n = 0;
        #1;
        check("rst_mid hi", hi, 0);
        check("rst_mid lo", lo, 0);
        check("rst_mid busy", {31'd0, busy}, 0);
        step();
        rst_n = 1;
        dcnt = 0;
        for (int n = 0; n < 40; n++) begin
            if (done) dcnt++;
            if (busy) dcnt++;
            step();
        end
        check("rst_mid no done_busy", dcnt, 0);
        check("rst_mid hi_after", hi, 0);
        check("rst_mid lo_after", lo, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
